iicmb_cmd_sequencer: RTL and testbench

Synthesizable Wishbone master that drives the IICMB I2C master core autonomously, replacing CPU or bench-driven register sequencing. It accepts one transfer request (bus, 7-bit address, read/write, length), then issues enable, set-bus, start, address, data and stop commands over Wishbone. It services irq after each command and streams write data in and read data out. It sits between a user request port and the DUT's Wishbone slave port and generalises the single-bus, write-only, fixed-length flow to N buses, both directions and variable length.

---
 rtl/iicmb_seq_pkg.sv | 51 +++++
 rtl/wb_single_master.sv | 65 ++++++
 rtl/iicmb_cmd_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_iicmb_cmd_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iicmb_seq_pkg.sv
// ============================================================================
//  Module   : iicmb_seq_pkg
//  Purpose  : IICMB register map, command codes, response bits and the
//             sequencer state encoding shared by the command sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package iicmb_seq_pkg;

  localparam int REG_CSR  = 0;
  localparam int REG_DPR  = 1;
  localparam int REG_CMDR = 2;

  localparam logic [7:0] CMD_WRITE    = 8'd1;
  localparam logic [7:0] CMD_READ_ACK = 8'd2;
  localparam logic [7:0] CMD_READ_NAK = 8'd3;
  localparam logic [7:0] CMD_START    = 8'd4;
  localparam logic [7:0] CMD_STOP     = 8'd5;
  localparam logic [7:0] CMD_SET_BUS  = 8'd6;

  localparam int RSP_DON = 7;
  localparam int RSP_NAK = 6;
  localparam int RSP_AL  = 5;
  localparam int RSP_ERR = 4;

  localparam logic [7:0] CSR_ENABLE = 8'hC0;

  typedef enum logic [4:0] {
    S_RESET_EN   = 5'd0,
    S_IDLE       = 5'd1,
    S_SETBUS_DPR = 5'd2,
    S_SETBUS_CMD = 5'd3,
    S_WAIT       = 5'd4,
    S_RD_STAT    = 5'd5,
    S_START      = 5'd6,
    S_ADDR_DPR   = 5'd7,
    S_ADDR_CMD   = 5'd8,
    S_DATA       = 5'd9,
    S_WR_GET     = 5'd10,
    S_WR_DPR     = 5'd11,
    S_WR_CMD     = 5'd12,
    S_RD_CMD     = 5'd13,
    S_RD_DPR     = 5'd14,
    S_STOP       = 5'd15,
    S_FIN        = 5'd16
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_single_master.sv
// ============================================================================
//  Module   : wb_single_master
//  Purpose  : One-shot Wishbone master; holds cyc/stb until the first ack,
//             then idles at least one cycle before accepting the next start.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_single_master #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i
);

  logic              cyc_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (!cyc_q) begin
      if (start_i) begin
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= wdata_i;
      end
    end else if (ack_i) begin
      cyc_q <= 1'b0;
    end
  end

  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign we_o    = we_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;
  assign busy_o  = cyc_q;
  assign done_o  = cyc_q & ack_i;
  assign rdata_o = dat_i;

endmodule

`default_nettype wire

// File: rtl/iicmb_cmd_sequencer.sv
// ============================================================================
//  Module   : iicmb_cmd_sequencer
//  Purpose  : Autonomous Wishbone master sequencing IICMB commands for one
//             I2C transfer request. Optional irq watchdog: IICMB_SEQ_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module iicmb_cmd_sequencer
  import iicmb_seq_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int NUM_I2C_BUSES  = 1,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int LEN_W = $clog2(MAX_LEN + 1),
  localparam int BUS_W = (NUM_I2C_BUSES > 1) ? $clog2(NUM_I2C_BUSES) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [BUS_W-1:0]          req_bus_i,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_rw_i,
  input  logic [LEN_W-1:0]          req_len_i,
  input  logic [7:0]                wr_data_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  output logic [7:0]                rd_data_o,
  output logic                      rd_valid_o,
  output logic                      done_o,
  output logic                      nak_o,
  output logic                      err_o,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

  seq_state_e                state_q;
  seq_state_e                ret_q;
  logic                      en_q;
  logic [BUS_W-1:0]          bus_q;
  logic [I2C_ADDR_WIDTH-1:0] addr_q;
  logic                      rw_q;
  logic [LEN_W-1:0]          cnt_q;
  logic [7:0]                wbyte_q;
  logic [7:0]                rd_data_q;
  logic                      rd_valid_q;
  logic                      done_q;
  logic                      nak_q;
  logic                      err_q;

  logic                     w_xfer;
  logic                     w_we;
  logic [WB_ADDR_WIDTH-1:0] w_adr;
  logic [WB_DATA_WIDTH-1:0] w_wdata;
  logic                     w_busy;
  logic                     w_done;
  logic [WB_DATA_WIDTH-1:0] w_rdata;

  // Each transfer state owns exactly one Wishbone access.
  always_comb begin
    w_xfer  = 1'b1;
    w_we    = 1'b1;
    w_adr   = WB_ADDR_WIDTH'(REG_CMDR);
    w_wdata = '0;
    unique case (state_q)
      S_RESET_EN: begin
        w_adr   = WB_ADDR_WIDTH'(REG_CSR);
        w_wdata = WB_DATA_WIDTH'(CSR_ENABLE);
      end
      S_SETBUS_DPR: begin
        w_adr   = WB_ADDR_WIDTH'(REG_DPR);
        w_wdata = WB_DATA_WIDTH'(bus_q);
      end
      S_SETBUS_CMD: w_wdata = WB_DATA_WIDTH'(CMD_SET_BUS);
      S_RD_STAT:    w_we    = 1'b0;
      S_START:      w_wdata = WB_DATA_WIDTH'(CMD_START);
      S_ADDR_DPR: begin
        w_adr   = WB_ADDR_WIDTH'(REG_DPR);
        w_wdata = WB_DATA_WIDTH'({addr_q, rw_q});
      end
      S_ADDR_CMD, S_WR_CMD: w_wdata = WB_DATA_WIDTH'(CMD_WRITE);
      S_WR_DPR: begin
        w_adr   = WB_ADDR_WIDTH'(REG_DPR);
        w_wdata = WB_DATA_WIDTH'(wbyte_q);
      end
      S_RD_CMD: w_wdata = WB_DATA_WIDTH'((cnt_q == LEN_W'(1)) ? CMD_READ_NAK : CMD_READ_ACK);
      S_RD_DPR: begin
        w_we  = 1'b0;
        w_adr = WB_ADDR_WIDTH'(REG_DPR);
      end
      S_STOP:   w_wdata = WB_DATA_WIDTH'(CMD_STOP);
      default:  w_xfer  = 1'b0;
    endcase
  end

  wb_single_master #(
    .ADDR_W (WB_ADDR_WIDTH),
    .DATA_W (WB_DATA_WIDTH)
  ) u_wb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_xfer & ~w_busy),
    .we_i    (w_we),
    .adr_i   (w_adr),
    .wdata_i (w_wdata),
    .busy_o  (w_busy),
    .done_o  (w_done),
    .rdata_o (w_rdata),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .dat_i   (dat_i),
    .ack_i   (ack_i)
  );

`ifdef IICMB_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_RESET_EN;
      ret_q      <= S_IDLE;
      en_q       <= 1'b0;
      bus_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      cnt_q      <= '0;
      wbyte_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      nak_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef IICMB_SEQ_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef IICMB_SEQ_TIMEOUT_EN
      if (state_q != S_WAIT) tmo_q <= '0;
`endif
      unique case (state_q)
        S_RESET_EN: if (w_done) begin
          en_q    <= 1'b1;
          state_q <= S_IDLE;
        end
        S_IDLE: if (req_valid_i && en_q) begin
          bus_q   <= req_bus_i;
          addr_q  <= req_addr_i;
          rw_q    <= req_rw_i;
          cnt_q   <= req_len_i;
          nak_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_SETBUS_DPR;
        end
        S_SETBUS_DPR: if (w_done) state_q <= S_SETBUS_CMD;
        S_SETBUS_CMD: if (w_done) begin
          ret_q   <= S_START;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (irq_i) begin
            state_q <= S_RD_STAT;
`ifdef IICMB_SEQ_TIMEOUT_EN
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            tmo_q   <= tmo_q + TMO_W'(1);
`endif
          end
        end
        // Bus-level failures abandon the transfer; a NAK still closes with STOP.
        S_RD_STAT: if (w_done) begin
          if (w_rdata[RSP_AL] || w_rdata[RSP_ERR]) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else if (w_rdata[RSP_NAK] && ret_q != S_FIN) begin
            nak_q   <= 1'b1;
            state_q <= S_STOP;
          end else if (ret_q == S_FIN) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            state_q <= ret_q;
          end
        end
        S_START: if (w_done) begin
          ret_q   <= S_ADDR_DPR;
          state_q <= S_WAIT;
        end
        S_ADDR_DPR: if (w_done) state_q <= S_ADDR_CMD;
        S_ADDR_CMD, S_WR_CMD: if (w_done) begin
          ret_q   <= S_DATA;
          state_q <= S_WAIT;
        end
        S_DATA: begin
          if (cnt_q == '0)  state_q <= S_STOP;
          else if (rw_q)    state_q <= S_RD_CMD;
          else              state_q <= S_WR_GET;
        end
        S_WR_GET: if (wr_valid_i) begin
          wbyte_q <= wr_data_i;
          cnt_q   <= cnt_q - LEN_W'(1);
          state_q <= S_WR_DPR;
        end
        S_WR_DPR: if (w_done) state_q <= S_WR_CMD;
        S_RD_CMD: if (w_done) begin
          ret_q   <= S_RD_DPR;
          state_q <= S_WAIT;
        end
        S_RD_DPR: if (w_done) begin
          rd_data_q  <= w_rdata[7:0];
          rd_valid_q <= 1'b1;
          cnt_q      <= cnt_q - LEN_W'(1);
          state_q    <= S_DATA;
        end
        S_STOP: if (w_done) begin
          ret_q   <= S_FIN;
          state_q <= S_WAIT;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_RESET_EN;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE) & en_q;
  assign wr_ready_o  = (state_q == S_WR_GET) & wr_valid_i;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign done_o      = done_q;
  assign nak_o       = done_q & nak_q;
  assign err_o       = done_q & err_q;

endmodule

`default_nettype wire

// File: tb/tb_iicmb_cmd_sequencer.sv
// ============================================================================
//  Module   : tb_iicmb_cmd_sequencer
//  Purpose  : Directed bench for iicmb_cmd_sequencer with an IICMB register
//             model answering on Wishbone and a single I2C slave at 0x22.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iicmb_cmd_sequencer;

  localparam logic [6:0] SLAVE = 7'h22;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rw;
  logic [1:0] req_bus;
  logic [6:0] req_addr;
  logic [5:0] req_len;
  logic [7:0] wr_data, rd_data;
  logic       wr_valid, wr_ready, rd_valid, done, nak, err;
  logic       cyc, stb, we, ack, irq;
  logic [1:0] adr;
  logic [7:0] dat_o, dat_i;

  always #5 clk = ~clk;

  iicmb_cmd_sequencer #(
    .WB_ADDR_WIDTH (2),
    .WB_DATA_WIDTH (8),
    .NUM_I2C_BUSES (4),
    .I2C_ADDR_WIDTH(7),
    .MAX_LEN       (32),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bus_i(req_bus),
    .req_addr_i(req_addr), .req_rw_i(req_rw), .req_len_i(req_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .done_o(done), .nak_o(nak), .err_o(err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- IICMB register model ----------------
  logic [7:0] m_csr, m_dpr, m_resp, addr_byte;
  logic [7:0] rd_pat [4];
  logic [7:0] cmd_log [$];
  logic [7:0] wbytes [$];
  int  irq_cnt, csr_writes, stop_cnt, bus_seen, rd_idx;
  bit  al_mode, irq_block, addr_phase;

  task automatic do_cmd(input logic [7:0] c);
    cmd_log.push_back(c);
    irq     = 1'b0;
    irq_cnt = 3;
    m_resp  = 8'h80;
    case (c)
      8'd6: bus_seen = int'(m_dpr);
      8'd4: begin
        addr_phase = 1'b1;
        if (al_mode) m_resp = 8'h20;
      end
      8'd1: begin
        if (addr_phase) begin
          addr_phase = 1'b0;
          addr_byte  = m_dpr;
          if (m_dpr[7:1] != SLAVE) m_resp = 8'h40;
        end else begin
          wbytes.push_back(m_dpr);
        end
      end
      8'd2, 8'd3: begin
        m_dpr = rd_pat[rd_idx % 4];
        rd_idx++;
      end
      8'd5: stop_cnt++;
      default: m_resp = 8'h90;
    endcase
  endtask

  initial begin
    ack = 0; irq = 0; dat_i = 0; m_csr = 0; m_dpr = 0; m_resp = 0; addr_byte = 0;
    irq_cnt = 0; csr_writes = 0; stop_cnt = 0; bus_seen = -1; rd_idx = 0;
    al_mode = 0; irq_block = 0; addr_phase = 0;
    rd_pat[0] = 8'hA5; rd_pat[1] = 8'h5A; rd_pat[2] = 8'h01; rd_pat[3] = 8'hFF;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack = 0; irq = 0; irq_cnt = 0; addr_phase = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0 && !irq_block) irq = 1'b1;
        end
        if (cyc && stb && !ack) begin
          ack = 1'b1;
          if (we) begin
            case (adr)
              2'd0: begin m_csr = dat_o; csr_writes++; end
              2'd1: m_dpr = dat_o;
              2'd2: do_cmd(dat_o);
              default: ;
            endcase
          end else begin
            case (adr)
              2'd2: begin dat_i = m_resp; irq = 1'b0; end
              2'd1: dat_i = m_dpr;
              default: dat_i = m_csr;
            endcase
          end
        end else begin
          ack = 1'b0;
        end
      end
    end
  end

  // ---------------- write-byte source ----------------
  int src_idx, src_base, stall_after, stall_left, wr_pulses;
  bit src_en;

  initial begin
    wr_valid = 0; wr_data = 0; src_idx = 0; src_base = 0;
    stall_after = -1; stall_left = 0; wr_pulses = 0; src_en = 0;
    forever begin
      @(negedge clk);
      if (stall_left > 0) stall_left--;
      wr_valid = src_en && (stall_left == 0);
      wr_data  = 8'(src_base + src_idx);
      #1;
      if (wr_ready) begin
        wr_pulses++;
        if (wr_valid) begin
          src_idx++;
          if (src_idx == stall_after) stall_left = 100;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  bit done_seen, nak_seen, err_seen;
  logic [7:0] rd_q [$];
  int cyc_cycles = 0;

  initial begin
    done_seen = 0; nak_seen = 0; err_seen = 0;
    forever begin
      @(negedge clk);
      #2;
      if (cyc) cyc_cycles++;
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) begin
        done_seen = 1; nak_seen = nak; err_seen = err;
      end
    end
  end

  task automatic clear_logs();
    cmd_log.delete(); wbytes.delete(); rd_q.delete();
    rd_idx = 0; stop_cnt = 0; bus_seen = -1; addr_byte = 8'h00;
    wr_pulses = 0; src_idx = 0; stall_after = -1; stall_left = 0;
    done_seen = 0; nak_seen = 0; err_seen = 0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    check(name, 32'(n < 2000), 1);
  endtask

  task automatic issue(input logic [1:0] b, input logic [6:0] a, input logic rw, input logic [5:0] len);
    wait_ready("req_ready_wait");
    req_bus = b; req_addr = a; req_rw = rw; req_len = len; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_seen && n < 20000) begin @(negedge clk); n++; end
    #3;
    check(name, 32'(done_seen), 1);
  endtask

  typedef struct {
    logic [1:0] bus;
    logic [6:0] addr;
    logic       rw;
    logic [5:0] len;
    bit         al;
    int e_nak, e_err, e_wr, e_rd, e_stop, e_ncmd;
  } vec_t;

  vec_t vt [8];

  initial begin
    int c0, c1, csr_before, n;
    vt[0] = '{2'd0, 7'h22, 1'b0, 6'd32, 1'b0, 0, 0, 32, 0, 1, 36};
    vt[1] = '{2'd0, 7'h22, 1'b1, 6'd4,  1'b0, 0, 0, 0,  4, 1, 8};
    vt[2] = '{2'd0, 7'h44, 1'b0, 6'd3,  1'b0, 1, 0, 0,  0, 1, 4};
    vt[3] = '{2'd3, 7'h22, 1'b0, 6'd0,  1'b0, 0, 0, 0,  0, 1, 4};
    vt[4] = '{2'd2, 7'h22, 1'b1, 6'd1,  1'b0, 0, 0, 0,  1, 1, 5};
    vt[5] = '{2'd1, 7'h22, 1'b0, 6'd2,  1'b1, 0, 1, 0,  0, 0, 2};
    vt[6] = '{2'd0, 7'h10, 1'b1, 6'd2,  1'b0, 1, 0, 0,  0, 1, 4};
    vt[7] = '{2'd1, 7'h22, 1'b0, 6'd5,  1'b0, 0, 0, 5,  0, 1, 9};

    rst = 1'b1; req_valid = 0; req_bus = 0; req_addr = 0; req_rw = 0; req_len = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cyc", 32'(cyc), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    rst = 1'b0;
    wait_ready("enable_ready");
    check("enable_count", 32'(csr_writes), 1);
    check("enable_value", 32'(m_csr), 32'hC0);

    for (int i = 0; i < 8; i++) begin
      clear_logs();
      al_mode  = vt[i].al;
      src_base = 16 * i;
      src_en   = !vt[i].rw;
      issue(vt[i].bus, vt[i].addr, vt[i].rw, vt[i].len);
      wait_done($sformatf("v%0d_done", i));
      src_en  = 0;
      al_mode = 0;
      check($sformatf("v%0d_nak", i),   32'(nak_seen), 32'(vt[i].e_nak));
      check($sformatf("v%0d_err", i),   32'(err_seen), 32'(vt[i].e_err));
      check($sformatf("v%0d_wr_pulses", i), 32'(wr_pulses), 32'(vt[i].e_wr));
      check($sformatf("v%0d_rd_count", i),  32'(rd_q.size()), 32'(vt[i].e_rd));
      check($sformatf("v%0d_stops", i), 32'(stop_cnt), 32'(vt[i].e_stop));
      check($sformatf("v%0d_ncmd", i),  32'(cmd_log.size()), 32'(vt[i].e_ncmd));
      check($sformatf("v%0d_bus", i),   32'(bus_seen), 32'(vt[i].bus));
      if (!vt[i].al)
        check($sformatf("v%0d_addr_byte", i), 32'(addr_byte), 32'({vt[i].addr, vt[i].rw}));
      check($sformatf("v%0d_wbytes", i), 32'(wbytes.size()), 32'(vt[i].e_wr));
      for (int j = 0; j < wbytes.size(); j++)
        check($sformatf("v%0d_wdata%0d", i, j), 32'(wbytes[j]), 32'(8'(src_base + j)));
      for (int j = 0; j < rd_q.size(); j++)
        check($sformatf("v%0d_rdata%0d", i, j), 32'(rd_q[j]), 32'(rd_pat[j % 4]));
      if (vt[i].e_rd > 0) begin
        check($sformatf("v%0d_last_rd_cmd", i), 32'(cmd_log[cmd_log.size()-2]), 3);
        if (vt[i].e_rd > 1) check($sformatf("v%0d_first_rd_cmd", i), 32'(cmd_log[3]), 2);
      end
    end

    // Write source stalls 100 cycles after the first byte.
    clear_logs();
    src_base = 8'h80; stall_after = 1; src_en = 1;
    issue(2'd0, SLAVE, 1'b0, 6'd4);
    n = 0;
    while (src_idx < 1 && n < 2000) begin @(negedge clk); n++; end
    check("stall_first_byte", 32'(n < 2000), 1);
    repeat (40) @(negedge clk);
    #3;
    c0 = cyc_cycles;
    check("stall_ready_low", 32'(wr_ready), 0);
    repeat (40) @(negedge clk);
    #3;
    c1 = cyc_cycles;
    check("stall_quiet", 32'(c1 - c0), 0);
    wait_done("stall_done");
    src_en = 0;
    check("stall_flags", 32'({nak_seen, err_seen}), 0);
    check("stall_wbytes", 32'(wbytes.size()), 4);
    for (int j = 0; j < wbytes.size(); j++)
      check($sformatf("stall_wdata%0d", j), 32'(wbytes[j]), 32'(8'h80 + j));

    // Reset in the middle of the data phase.
    clear_logs();
    src_base = 8'h20; src_en = 1;
    csr_before = csr_writes;
    issue(2'd0, SLAVE, 1'b0, 6'd8);
    n = 0;
    while (src_idx < 2 && n < 2000) begin @(negedge clk); n++; end
    while (!cyc && n < 2000) begin @(negedge clk); n++; end
    check("midrst_reach", 32'(n < 2000), 1);
    rst = 1'b1;
    #1;
    check("midrst_cyc", 32'(cyc), 0);
    check("midrst_stb", 32'(stb), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    src_en = 0;
    wait_ready("midrst_ready");
    check("midrst_reenable", 32'(csr_writes), 32'(csr_before + 1));
    clear_logs();
    src_base = 8'h30; src_en = 1;
    issue(2'd1, SLAVE, 1'b0, 6'd3);
    wait_done("post_rst_done");
    src_en = 0;
    check("post_rst_flags", 32'({nak_seen, err_seen}), 0);
    check("post_rst_wbytes", 32'(wbytes.size()), 3);
    for (int j = 0; j < wbytes.size(); j++)
      check($sformatf("post_rst_wdata%0d", j), 32'(wbytes[j]), 32'(8'h30 + j));

`ifdef IICMB_SEQ_TIMEOUT_EN
    clear_logs();
    irq_block = 1;
    issue(2'd0, SLAVE, 1'b0, 6'd1);
    wait_done("tmo_done");
    irq_block = 0;
    check("tmo_err", 32'(err_seen), 1);
    check("tmo_nak", 32'(nak_seen), 0);
    check("tmo_ncmd", 32'(cmd_log.size()), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
